// File: rtl/arm_row_streamer_pkg.sv
`default_nettype none
//==============================================================================
// arm_row_streamer_pkg : state encoding and {row, col} address-width helpers
// Revision : 1.0
//==============================================================================
package arm_row_streamer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_FETCH_A  = 3'd1,
      ST_FETCH_B  = 3'd2,
      ST_SHIFT_LO = 3'd3,
      ST_SHIFT_HI = 3'd4,
      ST_LATCH    = 3'd5
   } ars_state_t;

   // Frame RAM address is {row, col}; the frame-buffer writer uses these too.
   function automatic int ars_row_w(input int img_height);
      return $clog2(img_height);
   endfunction

   function automatic int ars_col_w(input int img_width);
      return $clog2(img_width);
   endfunction

   function automatic int ars_addr_w(input int img_height, input int img_width);
      return ars_row_w(img_height) + ars_col_w(img_width);
   endfunction

endpackage
`default_nettype wire

// File: rtl/arm_row_streamer.sv
`default_nettype none
//==============================================================================
// arm_row_streamer : fetches the two opposite-arm image rows from frame RAM and
//                    shifts them into the serial LED driver chains, then latches
// Revision : 1.0
//==============================================================================
module arm_row_streamer
   import arm_row_streamer_pkg::*;
#(
   parameter int IMG_HEIGHT = 64,
   parameter int IMG_WIDTH  = 32,
   parameter int PIX_W      = 3,
   parameter int SCLK_DIV   = 2
) (
   input  logic                                          clk,
   input  logic                                          nReset,
   input  logic [$clog2(IMG_HEIGHT)-1:0]                 row,
   input  logic [$clog2(IMG_HEIGHT)-1:0]                 rowEven,
   input  logic                                          valid,
   input  logic                                          rowChange,
   output logic                                          rd_en,
   output logic [$clog2(IMG_HEIGHT)+$clog2(IMG_WIDTH)-1:0] rd_addr,
   input  logic [PIX_W-1:0]                              rd_data,
   output logic                                          sclk,
   output logic [PIX_W-1:0]                              sdata_a,
   output logic [PIX_W-1:0]                              sdata_b,
   output logic                                          latch,
   output logic                                          oe_n,
   output logic                                          busy,
   output logic                                          overrun
);

   localparam int c_ROW_W = ars_row_w(IMG_HEIGHT);
   localparam int c_COL_W = ars_col_w(IMG_WIDTH);
   localparam int c_PH_W  = $clog2(SCLK_DIV) + 1;
   localparam logic [c_COL_W-1:0] c_COL_FIRST = c_COL_W'(IMG_WIDTH - 1);
   localparam logic [c_PH_W-1:0]  c_PH_LAST   = c_PH_W'(SCLK_DIV - 1);

   ars_state_t           r_state;
   ars_state_t           w_next;
   logic [c_ROW_W-1:0]   r_row_a;
   logic [c_ROW_W-1:0]   r_row_b;
   logic [c_ROW_W-1:0]   r_pend_a;
   logic [c_ROW_W-1:0]   r_pend_b;
   logic [c_COL_W-1:0]   r_col;
   logic [c_PH_W-1:0]    r_phase;
   logic [PIX_W-1:0]     r_dat_a;
   logic [PIX_W-1:0]     r_sdata_a;
   logic [PIX_W-1:0]     r_sdata_b;
   logic                 r_pending;
   logic                 r_ready;
   logic                 r_overrun;
   logic                 r_sclk;
   logic                 r_latch;
   logic                 r_oe_n;
   logic                 r_busy;
   logic                 w_ph_last;
   logic                 w_timed;
   logic                 w_row_done;
   logic                 w_reload;
   logic                 w_ready_next;

   assign w_ph_last  = (r_phase == c_PH_LAST);
   assign w_timed    = (r_state == ST_SHIFT_LO) || (r_state == ST_SHIFT_HI) || (r_state == ST_LATCH);
   assign w_row_done = valid && (r_state == ST_LATCH) && w_ph_last;
   // A pulse landing on the final latch cycle is chained directly instead of stranding a pending flag.
   assign w_reload   = w_row_done && (r_pending || rowChange);

   assign rd_en   = valid && ((r_state == ST_FETCH_A) || (r_state == ST_FETCH_B));
   assign rd_addr = (r_state == ST_FETCH_B) ? {r_row_b, r_col} : {r_row_a, r_col};

   assign sclk    = r_sclk;
   assign latch   = r_latch;
   assign oe_n    = r_oe_n;
   assign busy    = r_busy;
   assign overrun = r_overrun;
   assign sdata_a = r_sdata_a;
   assign sdata_b = r_sdata_b;

   always_comb begin
      w_next       = r_state;
      w_ready_next = r_ready;
      if (!valid) begin
         w_next       = ST_IDLE;
         w_ready_next = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE:     if (rowChange) w_next = ST_FETCH_A;
            ST_FETCH_A:  w_next = ST_FETCH_B;
            ST_FETCH_B:  w_next = ST_SHIFT_LO;
            ST_SHIFT_LO: if (w_ph_last) w_next = ST_SHIFT_HI;
            ST_SHIFT_HI: if (w_ph_last) w_next = (r_col == '0) ? ST_LATCH : ST_FETCH_A;
            ST_LATCH: begin
               if (w_ph_last) begin
                  w_ready_next = 1'b1;
                  w_next       = w_reload ? ST_FETCH_A : ST_IDLE;
               end
            end
            default:     w_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         r_state   <= ST_IDLE;
         r_row_a   <= '0;
         r_row_b   <= '0;
         r_col     <= '0;
         r_phase   <= '0;
         r_dat_a   <= '0;
         r_sdata_a <= '0;
         r_sdata_b <= '0;
         r_ready   <= 1'b0;
         r_sclk    <= 1'b0;
         r_latch   <= 1'b0;
         r_oe_n    <= 1'b1;
         r_busy    <= 1'b0;
      end else begin
         r_state <= w_next;
         r_sclk  <= (w_next == ST_SHIFT_HI);
         r_latch <= (w_next == ST_LATCH);
         r_busy  <= (w_next != ST_IDLE);
         r_ready <= w_ready_next;
         r_oe_n  <= !(valid && w_ready_next);

         if (!valid || !w_timed || w_ph_last)
            r_phase <= '0;
         else
            r_phase <= r_phase + c_PH_W'(1);

         if (valid) begin
            case (r_state)
               ST_IDLE: begin
                  if (rowChange) begin
                     r_row_a <= row;
                     r_row_b <= rowEven;
                     r_col   <= c_COL_FIRST;
                  end
               end
               ST_FETCH_B: r_dat_a <= rd_data;
               ST_SHIFT_LO: begin
                  // Arm B's pixel arrives now; both lanes then update together.
                  if (r_phase == '0) begin
                     r_sdata_a <= r_dat_a;
                     r_sdata_b <= rd_data;
                  end
               end
               ST_SHIFT_HI: if (w_ph_last && (r_col != '0)) r_col <= r_col - c_COL_W'(1);
               ST_LATCH: begin
                  if (w_reload) begin
                     r_row_a <= rowChange ? row     : r_pend_a;
                     r_row_b <= rowChange ? rowEven : r_pend_b;
                     r_col   <= c_COL_FIRST;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         r_pending <= 1'b0;
         r_pend_a  <= '0;
         r_pend_b  <= '0;
         r_overrun <= 1'b0;
      end else if (!valid) begin
         r_pending <= 1'b0;
      end else begin
         if (rowChange && (r_state != ST_IDLE))
            r_overrun <= 1'b1;
         if (w_row_done) begin
            r_pending <= 1'b0;
         end else if (rowChange && (r_state != ST_IDLE)) begin
            r_pending <= 1'b1;
            r_pend_a  <= row;
            r_pend_b  <= rowEven;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_arm_row_streamer.sv
`default_nettype none
//==============================================================================
// tb_arm_row_streamer : randomized self-checking bench against a row/column model
// Revision : 1.0
//==============================================================================
module tb_arm_row_streamer;

   localparam int H = 8;
   localparam int W = 4;
   localparam int P = 3;
   localparam int D = 2;
   localparam int ROW_CYC = W * (2 + 2 * D) + D;

   logic       clk = 1'b0;
   logic       nReset;
   logic [2:0] row;
   logic [2:0] rowEven;
   logic       valid;
   logic       rowChange;
   logic       rd_en;
   logic [4:0] rd_addr;
   logic [2:0] rd_data;
   logic       sclk;
   logic [2:0] sdata_a;
   logic [2:0] sdata_b;
   logic       latch;
   logic       oe_n;
   logic       busy;
   logic       overrun;

   int checks = 0;
   int errors = 0;

   logic [4:0] addr_q[$];
   logic [4:0] exp_addr[$];
   logic [5:0] shift_q[$];
   logic [5:0] exp_shift[$];
   int         latch_cyc;
   int         stable_err;
   logic       prev_sclk;
   logic [2:0] prev_sa;
   logic [2:0] prev_sb;

   always #5 clk = ~clk;

   arm_row_streamer #(
      .IMG_HEIGHT(H), .IMG_WIDTH(W), .PIX_W(P), .SCLK_DIV(D)
   ) dut (
      .clk(clk), .nReset(nReset), .row(row), .rowEven(rowEven), .valid(valid),
      .rowChange(rowChange), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .sclk(sclk), .sdata_a(sdata_a), .sdata_b(sdata_b), .latch(latch),
      .oe_n(oe_n), .busy(busy), .overrun(overrun)
   );

   function automatic logic [2:0] pix(input logic [4:0] a);
      return a[2:0] ^ a[4:2];
   endfunction

   // Frame RAM: one-cycle read latency, garbage whenever not strobed.
   always @(posedge clk) rd_data <= rd_en ? pix(rd_addr) : 3'($urandom);

   // Monitor: RAM reads, data captured on each sclk rise, latch width.
   always @(negedge clk) begin
      if (!nReset) begin
         prev_sclk = 1'b0;
         prev_sa   = '0;
         prev_sb   = '0;
      end else begin
         if (rd_en) addr_q.push_back(rd_addr);
         if (sclk && !prev_sclk) begin
            shift_q.push_back({prev_sa, prev_sb});
            if (sdata_a !== prev_sa || sdata_b !== prev_sb) stable_err++;
         end
         if (latch) latch_cyc++;
         prev_sclk = sclk;
         prev_sa   = sdata_a;
         prev_sb   = sdata_b;
      end
   end

   // Reference: highest column first, arm A then arm B for each column.
   task automatic add_row(input logic [2:0] ra, input logic [2:0] rb);
      for (int c = W - 1; c >= 0; c--) begin
         exp_addr.push_back({ra, 2'(c)});
         exp_addr.push_back({rb, 2'(c)});
         exp_shift.push_back({pix({ra, 2'(c)}), pix({rb, 2'(c)})});
      end
   endtask

   task automatic clear_mon;
      addr_q.delete();
      shift_q.delete();
      exp_addr.delete();
      exp_shift.delete();
      latch_cyc  = 0;
      stable_err = 0;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [2:0] r, input logic [2:0] re);
      row       = r;
      rowEven   = re;
      rowChange = 1'b1;
      tick;
      rowChange = 1'b0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 400) begin
         tick;
         n++;
      end
      if (busy) n = -1;
   endtask

   task automatic test_reset;
      nReset = 1'b0; valid = 1'b0; rowChange = 1'b0; row = '0; rowEven = '0;
      repeat (3) tick;
      checks++;
      if ({sclk, latch, oe_n, sdata_a, sdata_b, rd_en, rd_addr, busy, overrun} !== {3'b001, 6'd0, 1'b0, 5'd0, 2'b00}) begin
         errors++;
         $display("FAIL reset_values: got sclk=%b latch=%b oe_n=%b sa=%0d sb=%0d rd_en=%b addr=%0d busy=%b ovr=%b, want 0 0 1 0 0 0 0 0 0",
                  sclk, latch, oe_n, sdata_a, sdata_b, rd_en, rd_addr, busy, overrun);
      end
      nReset = 1'b1;
      tick;
   endtask

   task automatic test_single_transfer;
      logic [4:0] lit [8];
      int n;
      lit = '{5'd11, 5'd27, 5'd10, 5'd26, 5'd9, 5'd25, 5'd8, 5'd24};
      valid = 1'b1;
      repeat (2) tick;
      clear_mon;
      add_row(3'd2, 3'd6);
      pulse(3'd2, 3'd6);
      checks++;
      if (busy !== 1'b1 || rd_en !== 1'b1 || oe_n !== 1'b1) begin
         errors++;
         $display("FAIL single_start: got busy=%b rd_en=%b oe_n=%b, want 1 1 1", busy, rd_en, oe_n);
      end
      wait_idle(n);
      checks++;
      if (n !== ROW_CYC) begin errors++; $display("FAIL single_cycles: got %0d want %0d", n, ROW_CYC); end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (addr_q[i] !== lit[i]) begin errors++; $display("FAIL single_addr[%0d]: got %0d want %0d", i, addr_q[i], lit[i]); end
      end
      checks++;
      if (shift_q.size() !== 4) begin errors++; $display("FAIL single_rises: got %0d want 4", shift_q.size()); end
      for (int i = 0; i < exp_shift.size(); i++) begin
         checks++;
         if (shift_q[i] !== exp_shift[i]) begin errors++; $display("FAIL single_shift[%0d]: got %h want %h", i, shift_q[i], exp_shift[i]); end
      end
      checks++;
      if (latch_cyc !== D || stable_err !== 0) begin
         errors++;
         $display("FAIL single_latch_setup: got latch_cyc=%0d stable_err=%0d want %0d 0", latch_cyc, stable_err, D);
      end
      checks++;
      if (oe_n !== 1'b0 || sclk !== 1'b0 || latch !== 1'b0) begin
         errors++;
         $display("FAIL single_end: got oe_n=%b sclk=%b latch=%b want 0 0 0", oe_n, sclk, latch);
      end
   endtask

   task automatic test_overrun;
      logic [2:0] ra, rb, rd;
      int off, n;
      ra = 3'($urandom); rb = 3'($urandom); rd = 3'($urandom);
      off = $urandom_range(1, 25);
      clear_mon;
      checks++;
      if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_pre: got %b want 0", overrun); end
      add_row(ra, rb);
      add_row(3'd3, rd);
      pulse(ra, rb);
      repeat (off - 1) tick;
      pulse(3'd3, rd);
      checks++;
      if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b want 1", overrun); end
      wait_idle(n);
      checks++;
      if (off + n !== 2 * ROW_CYC) begin
         errors++;
         $display("FAIL overrun_chain_cycles: got %0d want %0d (off=%0d)", off + n, 2 * ROW_CYC, off);
      end
      checks++;
      if (addr_q.size() !== exp_addr.size()) begin errors++; $display("FAIL overrun_nreads: got %0d want %0d", addr_q.size(), exp_addr.size()); end
      for (int i = 0; i < exp_addr.size(); i++) begin
         checks++;
         if (addr_q[i] !== exp_addr[i]) begin errors++; $display("FAIL overrun_addr[%0d]: got %0d want %0d", i, addr_q[i], exp_addr[i]); end
      end
      for (int i = 0; i < exp_shift.size(); i++) begin
         checks++;
         if (shift_q[i] !== exp_shift[i]) begin errors++; $display("FAIL overrun_shift[%0d]: got %h want %h", i, shift_q[i], exp_shift[i]); end
      end
      checks++;
      if (latch_cyc !== 2 * D || overrun !== 1'b1) begin
         errors++;
         $display("FAIL overrun_end: got latch_cyc=%0d overrun=%b want %0d 1", latch_cyc, overrun, 2 * D);
      end
   endtask

   task automatic test_valid_drop;
      logic [2:0] ra, rb;
      int off, n;
      ra = 3'($urandom); rb = 3'($urandom);
      off = $urandom_range(7, 12);
      clear_mon;
      pulse(ra, rb);
      repeat (off - 1) tick;
      checks++;
      if (oe_n !== 1'b0) begin errors++; $display("FAIL drop_pre_oe: got %b want 0", oe_n); end
      valid = 1'b0;
      tick;
      checks++;
      if (busy !== 1'b0 || sclk !== 1'b0 || oe_n !== 1'b1 || latch !== 1'b0 || rd_en !== 1'b0) begin
         errors++;
         $display("FAIL drop_state: got busy=%b sclk=%b oe_n=%b latch=%b rd_en=%b want 0 0 1 0 0", busy, sclk, oe_n, latch, rd_en);
      end
      valid = 1'b1;
      repeat (3) tick;
      checks++;
      if (oe_n !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL drop_stays_blank: got oe_n=%b busy=%b want 1 0", oe_n, busy); end
      ra = 3'($urandom); rb = 3'($urandom);
      clear_mon;
      add_row(ra, rb);
      pulse(ra, rb);
      wait_idle(n);
      checks++;
      if (n !== ROW_CYC || oe_n !== 1'b0) begin errors++; $display("FAIL drop_fresh_end: got n=%0d oe_n=%b want %0d 0", n, oe_n, ROW_CYC); end
      for (int i = 0; i < exp_addr.size(); i++) begin
         checks++;
         if (addr_q[i] !== exp_addr[i]) begin errors++; $display("FAIL drop_fresh_addr[%0d]: got %0d want %0d", i, addr_q[i], exp_addr[i]); end
      end
      for (int i = 0; i < exp_shift.size(); i++) begin
         checks++;
         if (shift_q[i] !== exp_shift[i]) begin errors++; $display("FAIL drop_fresh_shift[%0d]: got %h want %h", i, shift_q[i], exp_shift[i]); end
      end
   endtask

   task automatic test_rowchange_invalid;
      valid = 1'b0;
      tick;
      clear_mon;
      pulse(3'($urandom), 3'($urandom));
      for (int k = 0; k < 10; k++) begin
         checks++;
         if (busy !== 1'b0 || oe_n !== 1'b1 || rd_en !== 1'b0) begin
            errors++;
            $display("FAIL invalid_idle[%0d]: got busy=%b oe_n=%b rd_en=%b want 0 1 0", k, busy, oe_n, rd_en);
         end
         tick;
      end
      checks++;
      if (addr_q.size() !== 0) begin errors++; $display("FAIL invalid_reads: got %0d want 0", addr_q.size()); end
      valid = 1'b1;
      tick;
   endtask

   task automatic test_random;
      logic [2:0] ra, rb;
      int n;
      for (int it = 0; it < 6; it++) begin
         ra = 3'($urandom); rb = 3'($urandom);
         repeat ($urandom_range(0, 3)) tick;
         clear_mon;
         add_row(ra, rb);
         pulse(ra, rb);
         wait_idle(n);
         checks++;
         if (n !== ROW_CYC || latch_cyc !== D || stable_err !== 0 || oe_n !== 1'b0) begin
            errors++;
            $display("FAIL rand%0d_timing: got n=%0d latch=%0d unstable=%0d oe_n=%b want %0d %0d 0 0",
                     it, n, latch_cyc, stable_err, oe_n, ROW_CYC, D);
         end
         for (int i = 0; i < exp_addr.size(); i++) begin
            checks++;
            if (addr_q[i] !== exp_addr[i]) begin errors++; $display("FAIL rand%0d_addr[%0d]: got %0d want %0d", it, i, addr_q[i], exp_addr[i]); end
         end
         for (int i = 0; i < exp_shift.size(); i++) begin
            checks++;
            if (shift_q[i] !== exp_shift[i]) begin errors++; $display("FAIL rand%0d_shift[%0d]: got %h want %h", it, i, shift_q[i], exp_shift[i]); end
         end
      end
   endtask

   task automatic test_reset_mid;
      int k, n;
      pulse(3'($urandom), 3'($urandom));
      k = 0;
      while (sclk !== 1'b1 && k < 30) begin tick; k++; end
      checks++;
      if (sclk !== 1'b1) begin errors++; $display("FAIL resetmid_reach_hi: got sclk=%b want 1", sclk); end
      nReset = 1'b0;
      #1;
      checks++;
      if ({sclk, latch, oe_n, sdata_a, sdata_b, rd_en, rd_addr, busy, overrun} !== {3'b001, 6'd0, 1'b0, 5'd0, 2'b00}) begin
         errors++;
         $display("FAIL resetmid_async: got sclk=%b latch=%b oe_n=%b sa=%0d sb=%0d rd_en=%b addr=%0d busy=%b ovr=%b, want 0 0 1 0 0 0 0 0 0",
                  sclk, latch, oe_n, sdata_a, sdata_b, rd_en, rd_addr, busy, overrun);
      end
      repeat (2) tick;
      nReset = 1'b1;
      repeat (2) tick;
      checks++;
      if (busy !== 1'b0 || rd_en !== 1'b0 || oe_n !== 1'b1) begin
         errors++;
         $display("FAIL resetmid_idle: got busy=%b rd_en=%b oe_n=%b want 0 0 1", busy, rd_en, oe_n);
      end
      clear_mon;
      pulse(3'($urandom), 3'($urandom));
      wait_idle(n);
      checks++;
      if (n !== ROW_CYC || oe_n !== 1'b0) begin errors++; $display("FAIL resetmid_recover: got n=%0d oe_n=%b want %0d 0", n, oe_n, ROW_CYC); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset;
      test_single_transfer;
      test_overrun;
      test_valid_drop;
      test_rowchange_invalid;
      test_random;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/arm_row_streamer.md
# arm_row_streamer

Consumes the row-position outputs of the turn timer (`row`, `rowEven`, `valid`, `rowChange`) and streams the two corresponding image rows from frame RAM into the serial LED driver chains of the two opposite rotor arms. On each `rowChange` it fetches one pixel per column for arm A (`row`) and arm B (`rowEven`), shifts both arms out in parallel, then pulses `latch`. It sits between the turn timer and the LED driver pins, and holds the display blanked whenever rotation timing is not valid.

## Interface
- `IMG_HEIGHT`, 64: rows per revolution; must match the turn timer.
- `IMG_WIDTH`, 32: LEDs per arm, one pixel per column.
- `PIX_W`, 3: bits per pixel; one serial data lane per bit.
- `SCLK_DIV`, 2: clk cycles per `sclk` half-period; must be ≥1.
- `clk` in 1: system clock.
- `nReset` in 1: reset, asynchronous, active-low.
- `row` in $clog2(IMG_HEIGHT): arm A row.
- `rowEven` in $clog2(IMG_HEIGHT): arm B row.
- `valid` in 1: rotation timing valid.
- `rowChange` in 1: one-cycle pulse; a new row pair is present on `row`/`rowEven`.
- `rd_en` out 1: frame RAM read strobe.
- `rd_addr` out $clog2(IMG_HEIGHT)+$clog2(IMG_WIDTH): read address {row, col}.
- `rd_data` in PIX_W: RAM data, valid exactly 1 cycle after `rd_en`.
- `sclk` out 1: shift clock; data is sampled on the rising edge.
- `sdata_a`, `sdata_b` out PIX_W: serial data for arm A and arm B.
- `latch` out 1: driver latch strobe.
- `oe_n` out 1: driver output enable, active-low.
- `busy` out 1: a row transfer is in progress (state ≠ IDLE).
- `overrun` out 1: sticky flag; a `rowChange` arrived while `busy`.

## Operation
- States: IDLE, FETCH_A, FETCH_B, SHIFT_LO, SHIFT_HI, LATCH.
- IDLE: when `rowChange` and `valid` are both high, capture `row`→rA and `rowEven`→rB, set col = IMG_WIDTH-1, and go to FETCH_A.
- FETCH_A: `rd_en`=1, `rd_addr`={rA,col}, then go to FETCH_B.
- FETCH_B: `rd_en`=1, `rd_addr`={rB,col}; register `rd_data` into datA at the end of this cycle. Go to SHIFT_LO.
- SHIFT_LO: runs for SCLK_DIV cycles with `sclk`=0. The first cycle registers `rd_data` into datB. `sdata_a`=datA and `sdata_b`=datB from the second cycle of SHIFT_LO until the next column's data replaces them.
- SHIFT_HI: runs for SCLK_DIV cycles with `sclk`=1. Afterwards, if col==0 go to LATCH; otherwise decrement col and go to FETCH_A.
- Column order: the highest column is shifted first, so column 0 ends nearest the data input.
- LATCH: `latch`=1 for SCLK_DIV cycles, and the arm-ready flag is set. Then:
  - if the pending flag is set, clear it, load rA/rB from the pending registers, set col = IMG_WIDTH-1 and go to FETCH_A;
  - otherwise go to IDLE.
- `rowChange` while `busy`: store `row`/`rowEven` into the pending registers (the latest pulse wins), set the pending flag, and set `overrun`=1. `overrun` clears only on reset.
- `valid` low in any state, checked before all other conditions:
  - next state is IDLE;
  - the pending flag and the arm-ready flag are cleared;
  - `sclk`, `latch` and `rd_en` are 0.
- `oe_n` = !(`valid` && arm-ready). The display stays blank until the first complete latch after `valid` rises.
- `rowChange` coinciding with `valid` falling is ignored.

## Timing
- All outputs are registered except `rd_addr`/`rd_en`, which decode from state and counters.
- Reset values:
  - outputs: `sclk`=0, `latch`=0, `oe_n`=1, `sdata_a`=`sdata_b`=0, `rd_en`=0, `rd_addr`=0, `busy`=0, `overrun`=0;
  - internal: state IDLE, flags 0.
- From `rowChange` high in IDLE, FETCH_A starts on the next cycle.
- Per column: 2+2·SCLK_DIV cycles.
- Per row: IMG_WIDTH·(2+2·SCLK_DIV)+SCLK_DIV cycles, followed by IDLE. With the defaults this is 194 cycles.
- `sdata` is stable for ≥SCLK_DIV-1 cycles before each `sclk` rise; SCLK_DIV=1 gives 0 cycles of setup before the rising edge.
- The col counter uses $clog2(IMG_WIDTH) bits and the phase counter $clog2(SCLK_DIV)+1 bits. Neither counter wraps: col terminates at 0.

## Structure
- `arm_row_streamer_pkg` holds:
  - the state enum `ars_state_t`;
  - the address-width localparam functions shared with the frame-buffer writer, so that {row, col} packing is defined in one place.
- No sub-module. The transfer FSM and the sclk phase counter are a single always_ff block; the pending and overrun capture is a second block.

## Test plan
All scenarios use IMG_HEIGHT=8, IMG_WIDTH=4, PIX_W=3, SCLK_DIV=2, and a RAM model returning data = addr[2:0] XOR {row LSBs}.
- Reset mid-transfer (assert `nReset` low during SHIFT_HI) → all outputs return to their reset values asynchronously; after release the block is in IDLE with `busy`=0.
- `valid`=1, `rowChange` with `row`=2, `rowEven`=6:
  - `rd_addr` sequence is 11,27,10,26,9,25,8,24;
  - 4 `sclk` rises, then `latch` high for 2 cycles;
  - total 26 cycles, then `oe_n` falls.
- Second `rowChange` (`row`=3) issued 5 cycles into a transfer → `overrun`=1. After the latch, FETCH_A starts immediately with rA=3, and no IDLE cycle occurs in between.
- `valid` dropped during column 2 → next cycle: IDLE, `sclk`=0, `oe_n`=1. A later `rowChange` with `valid`=1 produces a full fresh transfer.
- `rowChange` with `valid`=0 → no `rd_en`, `busy` stays 0, `oe_n` stays 1.
